// File: rtl/cl_div_pkg.sv
// Shared types and constants for the dual-mode (integer / carry-less) divider.
package cl_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ZERO,
        FIN
    } state_t;

    localparam logic MODE_INT = 1'b1;
    localparam logic MODE_CL  = 1'b0;

    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/cl_divider_msb_index.sv
// Priority encoder: index of the highest set bit, 0 when the input is 0.
module msb_index #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    output logic [IDX_W-1:0] index
);

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) index = IDX_W'(i);
        end
    end

endmodule

// File: rtl/cl_divider.sv
// Iterative divider, one quotient bit per clock: restoring integer division
// (carry_option=1) or GF(2)[x] polynomial division (carry_option=0).
module cl_divider
    import cl_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             carry_option,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t state, state_next;

    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic             mode_lat;
    logic [CNT_W-1:0] deg_b;
    logic [CNT_W-1:0] deg_b_in;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;

    logic             accept;
    logic             a_bit;
    logic             take;
    logic [WIDTH:0]   rs;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   r_step;

    msb_index #(
        .WIDTH (WIDTH),
        .IDX_W (CNT_W)
    ) u_msb_index (
        .value (b),
        .index (deg_b_in)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (b == '0) ? ZERO : RUN;
                end
            end
            RUN:     if (cnt == '0) state_next = FIN;
            ZERO:    state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One division step: shift in the next dividend bit, then conditionally
    // subtract (integer) or XOR (polynomial) the divisor.
    always_comb begin
        a_bit = a_lat[cnt];
        rs    = (r << 1) | {{WIDTH{1'b0}}, a_bit};
        diff  = rs - {1'b0, b_lat};
        if (mode_lat == MODE_INT) begin
            take   = (rs >= {1'b0, b_lat});
            r_step = take ? diff : rs;
        end else begin
            take   = rs[deg_b];
            r_step = take ? (rs ^ {1'b0, b_lat}) : rs;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_lat       <= '0;
            b_lat       <= '0;
            mode_lat    <= MODE_INT;
            deg_b       <= '0;
            cnt         <= '0;
            r           <= '0;
            q           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_lat       <= a;
                        b_lat       <= b;
                        mode_lat    <= carry_option;
                        deg_b       <= deg_b_in;
                        cnt         <= CNT_W'(WIDTH - 1);
                        r           <= '0;
                        q           <= '0;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                    end
                end
                RUN: begin
                    r      <= r_step;
                    q[cnt] <= take;
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                ZERO: begin
                    q <= '1;
                    r <= {1'b0, a_lat};
                end
                FIN: begin
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    quotient    <= q;
                    remainder   <= r[WIDTH-1:0];
                    div_by_zero <= (b_lat == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cl_divider.sv
// Directed-vector bench for cl_divider: table of operand/result records plus
// hand-written sequences for start-while-busy and mid-operation reset.
module tb_cl_divider;
    import cl_div_pkg::*;

    localparam int W     = 32;
    localparam int LIMIT = W + 20;
    localparam int LAT   = W + 2;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic         carry_option;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int errors = 0;
    int checks = 0;

    cl_divider #(.WIDTH(W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .carry_option (carry_option),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_by_zero  (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         mode;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [W-1:0] actual,
                         input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one operation, then scrambles the inputs so any late sampling
    // shows up. Returns edges from acceptance to the done edge, and whether
    // busy stayed high on every cycle before done.
    task automatic run_op(input logic mode, input logic [W-1:0] av,
                          input logic [W-1:0] bv, output int lat,
                          output logic busy_ok);
        @(negedge clk);
        start = 1'b1; carry_option = mode; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; carry_option = ~mode; a = $urandom; b = $urandom;
        lat     = 1;
        busy_ok = busy;
        while (!done && lat < LIMIT) begin
            @(negedge clk);
            lat++;
            if (!done && !busy) busy_ok = 1'b0;
        end
    endtask

    initial begin
        int           lat;
        int           pulses;
        logic         busy_ok;
        logic [W-1:0] got_q;
        logic [W-1:0] got_r;

        vecs[0]  = '{"int_29_5",     MODE_INT, 32'd29,         32'd5,  32'd5,          32'd4,      1'b0, LAT};
        vecs[1]  = '{"cl_1d_5",      MODE_CL,  32'h1D,         32'h5,  32'h6,          32'h3,      1'b0, LAT};
        vecs[2]  = '{"int_3_10",     MODE_INT, 32'd3,          32'd10, 32'd0,          32'd3,      1'b0, LAT};
        vecs[3]  = '{"cl_3_10",      MODE_CL,  32'd3,          32'd10, 32'd0,          32'd3,      1'b0, LAT};
        vecs[4]  = '{"int_max_1",    MODE_INT, 32'hFFFFFFFF,   32'd1,  32'hFFFFFFFF,   32'd0,      1'b0, LAT};
        vecs[5]  = '{"cl_max_1",     MODE_CL,  32'hFFFFFFFF,   32'd1,  32'hFFFFFFFF,   32'd0,      1'b0, LAT};
        vecs[6]  = '{"int_100_7",    MODE_INT, 32'd100,        32'd7,  32'd14,         32'd2,      1'b0, LAT};
        vecs[7]  = '{"cl_100_7",     MODE_CL,  32'd100,        32'd7,  32'h17,         32'd1,      1'b0, LAT};
        vecs[8]  = '{"int_zero",     MODE_INT, 32'h1234,       32'd0,  32'hFFFFFFFF,   32'h1234,   1'b1, 3};
        vecs[9]  = '{"int_dead_10",  MODE_INT, 32'hDEADBEEF,   32'h10, 32'h0DEADBEE,   32'hF,      1'b0, LAT};
        vecs[10] = '{"cl_zero",      MODE_CL,  32'h1234,       32'd0,  32'hFFFFFFFF,   32'h1234,   1'b1, 3};
        vecs[11] = '{"int_7_7",      MODE_INT, 32'd7,          32'd7,  32'd1,          32'd0,      1'b0, LAT};

        resetn = 1'b0; start = 1'b0; carry_option = MODE_INT; a = '0; b = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        check("reset_dz", {31'd0, div_by_zero}, 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].mode, vecs[i].a, vecs[i].b, lat, busy_ok);
            check({vecs[i].name, "_latency"}, W'(lat), W'(vecs[i].lat));
            check({vecs[i].name, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
            check({vecs[i].name, "_busy_done"}, {31'd0, busy}, 32'd0);
            check({vecs[i].name, "_quotient"}, quotient, vecs[i].q);
            check({vecs[i].name, "_remainder"}, remainder, vecs[i].r);
            check({vecs[i].name, "_dz"}, {31'd0, div_by_zero}, {31'd0, vecs[i].dz});
            @(negedge clk);
            check({vecs[i].name, "_done_pulse"}, {31'd0, done}, 32'd0);
        end

        // Divide-by-zero flag clears as soon as the next start is accepted.
        run_op(MODE_INT, 32'h1234, 32'd0, lat, busy_ok);
        check("dz_set", {31'd0, div_by_zero}, 32'd1);
        @(negedge clk);
        start = 1'b1; carry_option = MODE_INT; a = 32'd29; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        check("dz_clear_on_start", {31'd0, div_by_zero}, 32'd0);
        lat = 1;
        while (!done && lat < LIMIT) begin @(negedge clk); lat++; end
        check("dz_next_latency", W'(lat), W'(LAT));
        check("dz_next_quotient", quotient, 32'd5);

        // Second start at cycle 5 must be ignored.
        @(negedge clk);
        start = 1'b1; carry_option = MODE_INT; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; carry_option = MODE_CL; a = 32'd29; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; got_q = '0; got_r = '0;
        for (int k = 0; k < 2 * W; k++) begin
            if (done) begin pulses++; got_q = quotient; got_r = remainder; end
            @(negedge clk);
        end
        check("busy_start_pulses", W'(pulses), 32'd1);
        check("busy_start_quotient", got_q, 32'd14);
        check("busy_start_remainder", got_r, 32'd2);

        // Reset for one cycle at cycle 10 of an operation.
        @(negedge clk);
        start = 1'b1; carry_option = MODE_INT; a = 32'hDEADBEEF; b = 32'h10;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_remainder", remainder, 32'd0);
        check("midrst_dz", {31'd0, div_by_zero}, 32'd0);
        pulses = 0;
        for (int k = 0; k < W + 5; k++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("midrst_no_done", W'(pulses), 32'd0);
        run_op(MODE_INT, 32'd29, 32'd5, lat, busy_ok);
        check("midrst_fresh_latency", W'(lat), W'(LAT));
        check("midrst_fresh_quotient", quotient, 32'd5);
        check("midrst_fresh_remainder", remainder, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
